// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction fetch unit: opcodes,
// fetch state encoding and the default reset PC.
package mips_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned OPCODE_W       = 6;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC arithmetic for the fetch unit.
// Ports:
//   pc          current PC
//   imm16       branch immediate (instr[15:0])
//   take_branch branch & zero for the presented instruction
//   pc_plus4    pc + 4 (modulo 2^ADDR_W)
//   next_pc     branch target when take_branch, else pc_plus4
module pc_next #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [15:0]       imm16,
    input  logic              take_branch,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] next_pc
);

    localparam int unsigned EXT_W = ADDR_W - 18;

    logic [ADDR_W-1:0] br_off;

    // Word offset: sign-extended immediate shifted left by two.
    assign br_off = {{EXT_W{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        pc_plus4 = pc + ADDR_W'(4);
        next_pc  = pc_plus4;
        if (take_branch) begin
            next_pc = pc_plus4 + br_off;
        end
    end

endmodule

// File: rtl/mips_ifetch.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack
// handshake and presents each instruction until downstream accepts it.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   imem_req/addr/ack/rdata  instruction memory handshake
//   instr_valid/ready        presentation handshake to controller/datapath
//   instr, opcode, pc, pc_plus4  presented instruction and its address
//   branch, zero             resolved branch decision, used on accept
module mips_ifetch
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              branch,
    input  logic              zero
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] next_pc;

    pc_next #(
        .ADDR_W(ADDR_W)
    ) u_pc_next (
        .pc         (pc_q),
        .imm16      (instr_q[15:0]),
        .take_branch(branch & zero),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; req/valid flops follow the state being entered.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_d   = (state_d == ST_REQ);
        valid_d = (state_d == ST_HOLD);
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc          = pc_q;

endmodule

// File: tb/tb_mips_ifetch.sv
// Randomized self-checking bench for mips_ifetch with a transaction-level
// reference model of the PC sequence.
module tb_mips_ifetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch;
    logic        zero;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_pc;

    mips_ifetch #(
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .opcode     (opcode),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .branch     (branch),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_presented(input logic [31:0] word);
        logic [31:0] w;
        w = word;
        check("valid", 32'(instr_valid), 32'd1);
        check("req_hold", 32'(imem_req), 32'd0);
        check("instr", instr, w);
        check("opcode", 32'(opcode), 32'(w[31:26]));
        check("pc", pc, exp_pc);
        check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    endtask

    // One fetch transaction starting in REQ; updates the PC model on accept.
    task automatic do_fetch(input logic [31:0] word, input int ack_dly, input int hold,
                            input logic br, input logic zr);
        logic [15:0] imm;
        int          off;
        for (int i = 0; i < ack_dly; i++) begin
            check("req_wait", 32'(imem_req), 32'd1);
            check("addr_wait", imem_addr, exp_pc);
            check("valid_wait", 32'(instr_valid), 32'd0);
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            step();
        end
        check("req", 32'(imem_req), 32'd1);
        check("addr", imem_addr, exp_pc);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check_presented(word);
        for (int i = 0; i < hold; i++) begin
            instr_ready = 1'b0;
            imem_ack    = 1'($urandom % 2);
            branch      = 1'($urandom % 2);
            zero        = 1'($urandom % 2);
            step();
            check_presented(word);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        branch      = br;
        zero        = zr;
        step();
        instr_ready = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        imm = word[15:0];
        off = (br && zr) ? int'($signed(imm)) * 4 : 0;
        exp_pc = exp_pc + 32'd4 + 32'(off);
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        exp_pc      = 32'h0;
        repeat (3) step();

        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_opcode", 32'(opcode), 32'h0);

        rst_n = 1'b1;
        check("idle_req", 32'(imem_req), 32'd0);
        step();

        // Zero-wait LW at reset PC.
        do_fetch(32'h8C01_0004, 0, 0, 1'b0, 1'b0);
        // Sequential fetches with 2-cycle ack delay.
        do_fetch(32'h0000_0020, 2, 0, 1'b1, 1'b0);
        do_fetch(32'hAC22_0008, 2, 0, 1'b0, 1'b1);
        do_fetch(32'h0043_2020, 2, 0, 1'b0, 1'b0);
        // BEQ at 0x10 taken back onto itself, then not taken.
        check("beq_pc", exp_pc, 32'h10);
        do_fetch(32'h1000_FFFF, 0, 0, 1'b1, 1'b1);
        check("beq_taken_addr", imem_addr, 32'h10);
        do_fetch(32'h1000_FFFF, 0, 5, 1'b1, 1'b0);
        check("beq_fall_addr", imem_addr, 32'h14);
        // Branch back to 0, then to 0xFFFF_FFFC, then wrap.
        do_fetch(32'h1000_FFFA, 1, 0, 1'b1, 1'b1);
        check("back_to_zero", imem_addr, 32'h0);
        do_fetch(32'h1000_FFFE, 0, 0, 1'b1, 1'b1);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'h2000_0000, 0, 1, 1'b0, 1'b0);
        check("wrap_addr", imem_addr, 32'h0);

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            do_fetch($urandom, int'($urandom % 4), int'($urandom % 4),
                     1'($urandom % 2), 1'($urandom % 2));
        end

        // Reset asserted mid-REQ; late ack after release is ignored.
        do_fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(imem_req), 32'd0);
        check("rst_mid_valid", 32'(instr_valid), 32'd0);
        check("rst_mid_pc", pc, 32'h0);
        step();
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        exp_pc   = 32'h0;
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        do_fetch(32'h8C01_0004, 1, 0, 1'b0, 1'b0);
        check("restart_next", imem_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
